// File: rtl/lcd_adapter_pkg.sv
// ============================================================================
// Module   : lcd_adapter_pkg
// Purpose  : Shared constants and fill-counter states for the LCD 8<->24 bit
//            stream adapters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_adapter_pkg;

  localparam int SYMBOL_W = 8;
  localparam int SYMBOLS  = 3;
  localparam int OUT_W    = SYMBOL_W * SYMBOLS;
  localparam int EMPTY_W  = 2;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2
  } fill_state_t;

endpackage

`default_nettype wire

// File: rtl/lcd_8_to_24_bits_out_reg.sv
// ============================================================================
// Module   : lcd_8_to_24_bits_out_reg
// Purpose  : Source-side holding register for the 8->24 packer. Optional
//            out_empty field present when LCD_PACKER_EMPTY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_8_to_24_bits_out_reg
  import lcd_adapter_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [OUT_W-1:0]   load_data,
  input  logic               load_sop,
  input  logic               load_eop,
`ifdef LCD_PACKER_EMPTY_EN
  input  logic [EMPTY_W-1:0] load_empty,
  output logic [EMPTY_W-1:0] out_empty,
`endif
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic               free
);

  logic               r_valid;
  logic [OUT_W-1:0]   r_data;
  logic               r_sop;
  logic               r_eop;

  // The register can take a new beat whenever the current one leaves this cycle.
  assign free = ~r_valid | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
      r_sop   <= load_sop;
      r_eop   <= load_eop;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef LCD_PACKER_EMPTY_EN
  logic [EMPTY_W-1:0] r_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_empty <= '0;
    end else if (load) begin
      r_empty <= load_empty;
    end
  end

  assign out_empty = r_empty;
`endif

  assign out_valid         = r_valid;
  assign out_data          = r_data;
  assign out_startofpacket = r_sop;
  assign out_endofpacket   = r_eop;

endmodule

`default_nettype wire

// File: rtl/lcd_8_to_24_bits_packer.sv
// ============================================================================
// Module   : lcd_8_to_24_bits_packer
// Purpose  : Avalon-ST adapter packing 8-bit symbols into 24-bit beats, first
//            symbol in the MSBs. Define LCD_PACKER_EMPTY_EN for out_empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_8_to_24_bits_packer
  import lcd_adapter_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SYMBOL_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_startofpacket,
  input  logic                in_endofpacket,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_startofpacket,
  output logic                out_endofpacket,
`ifdef LCD_PACKER_EMPTY_EN
  output logic [EMPTY_W-1:0]  out_empty,
`endif
  output logic                drop_pulse
);

  fill_state_t                 r_cnt;
  fill_state_t                 w_cnt_nxt;
  fill_state_t                 w_pos;
  // Only the two leading symbols ever wait here; the third completes the beat.
  logic [OUT_W-SYMBOL_W-1:0]   r_acc;
  logic                        r_sop_flag;
  logic                        r_drop;
  logic                        r_rst_done;
  logic                        w_free;
  logic                        w_accept;
  logic                        w_restart;
  logic                        w_complete;
  logic [OUT_W-1:0]            w_beat;
  logic                        w_beat_sop;

  assign in_ready   = r_rst_done & w_free;
  assign w_accept   = in_valid & in_ready;
  assign w_restart  = in_startofpacket & (r_cnt != FILL0);
  assign w_pos      = w_restart ? FILL0 : r_cnt;
  assign w_complete = w_accept & ((w_pos == FILL2) | in_endofpacket);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= FILL0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_beat     = '0;
    w_beat_sop = r_sop_flag;
    case (w_pos)
      FILL0: begin
        w_beat     = {in_data, {(2*SYMBOL_W){1'b0}}};
        w_beat_sop = in_startofpacket;
      end
      FILL1:   w_beat = {r_acc[2*SYMBOL_W-1:SYMBOL_W], in_data, {SYMBOL_W{1'b0}}};
      default: w_beat = {r_acc, in_data};
    endcase
    if (w_accept) begin
      if (w_complete) begin
        w_cnt_nxt = FILL0;
      end else if (w_pos == FILL0) begin
        w_cnt_nxt = FILL1;
      end else begin
        w_cnt_nxt = FILL2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_sop_flag <= 1'b0;
      r_drop     <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      r_drop     <= w_accept & w_restart;
      if (w_accept) begin
        r_acc <= w_beat[OUT_W-1:SYMBOL_W];
        if (w_pos == FILL0) begin
          r_sop_flag <= in_startofpacket;
        end
      end
    end
  end

  assign drop_pulse = r_drop;

`ifdef LCD_PACKER_EMPTY_EN
  logic [EMPTY_W-1:0] w_empty;

  always_comb begin
    w_empty = '0;
    case (w_pos)
      FILL0:   w_empty = EMPTY_W'(2);
      FILL1:   w_empty = EMPTY_W'(1);
      default: w_empty = '0;
    endcase
  end
`endif

  lcd_8_to_24_bits_out_reg u_out_reg (
    .clk               (clk),
    .reset_n           (reset_n),
    .load              (w_complete),
    .load_data         (w_beat),
    .load_sop          (w_beat_sop),
    .load_eop          (in_endofpacket),
`ifdef LCD_PACKER_EMPTY_EN
    .load_empty        (w_empty),
    .out_empty         (out_empty),
`endif
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .free              (w_free)
  );

endmodule

`default_nettype wire
